// File: rtl/mp_reg_file_sb.sv
// mp_reg_file_sb: multi-ported register file with write bypass, pending scoreboard and reset sweep
module mp_reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 8,
  parameter int NWR      = 3,
  parameter int NAL      = 4,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        wr_en,
  input  logic [NWR*ADDR_W-1:0] wr_addr,
  input  logic [NWR*DATA_W-1:0] wr_data,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_ready,
  input  logic [NAL-1:0]        al_en,
  input  logic [NAL*ADDR_W-1:0] al_addr,
  output logic                  init_done
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(NREG - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic [NRD-1:0] hit;
  logic [DATA_W-1:0] byp [NRD];
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end
  always_ff @(posedge clk) mem_q <= mem_d;
  always_comb state_d = (state_q == INIT && cnt_q == LAST) ? RUN : state_q;
  // ascending port loops make the highest-numbered port win, matching the bypass below
  always_comb begin
    cnt_d  = cnt_q;
    mem_d  = mem_q;
    pend_d = pend_q;
    if (state_q == INIT) begin
      mem_d[cnt_q[ADDR_W-1:0]]  = '0;
      pend_d[cnt_q[ADDR_W-1:0]] = 1'b0;
      cnt_d = cnt_q + 1'b1;
    end else begin
      for (int i = 0; i < NWR; i++)
        if (wr_en[i] && !(ZERO_REG != 0 && wr_addr[i*ADDR_W +: ADDR_W] == '0))
          mem_d[wr_addr[i*ADDR_W +: ADDR_W]] = wr_data[i*DATA_W +: DATA_W];
      for (int i = 0; i < NWR; i++)
        if (wr_en[i]) pend_d[wr_addr[i*ADDR_W +: ADDR_W]] = 1'b0;
      for (int j = 0; j < NAL; j++)
        if (al_en[j]) pend_d[al_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
      if (ZERO_REG != 0) pend_d[0] = 1'b0;
    end
  end
  always_comb begin
    init_done = state_q == RUN;
    rd_data   = '0;
    rd_ready  = '0;
    hit       = '0;
    for (int r = 0; r < NRD; r++) byp[r] = '0;
    for (int r = 0; r < NRD; r++) begin
      for (int i = 0; i < NWR; i++)
        if (wr_en[i] && wr_addr[i*ADDR_W +: ADDR_W] == rd_addr[r*ADDR_W +: ADDR_W]) begin
          hit[r] = 1'b1;
          byp[r] = wr_data[i*DATA_W +: DATA_W];
        end
      if (state_q == RUN) begin
        if (ZERO_REG != 0 && rd_addr[r*ADDR_W +: ADDR_W] == '0) rd_ready[r] = 1'b1;
        else begin
          rd_data[r*DATA_W +: DATA_W] = hit[r] ? byp[r] : mem_q[rd_addr[r*ADDR_W +: ADDR_W]];
          rd_ready[r] = hit[r] | ~pend_q[rd_addr[r*ADDR_W +: ADDR_W]];
        end
      end
    end
  end
endmodule

// File: tb/tb_mp_reg_file_sb.sv
// tb_mp_reg_file_sb: directed vector table, sweep/reset sequences and random traffic against a reference model
module tb_mp_reg_file_sb;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] wr_en;
  logic [14:0] wr_addr;
  logic [95:0] wr_data;
  logic [39:0] rd_addr;
  logic [255:0] rd_data;
  logic [7:0] rd_ready;
  logic [3:0] al_en;
  logic [19:0] al_addr;
  logic init_done;
  int errors = 0;
  int checks = 0;
  logic [31:0] m_mem [32];
  logic m_pend [32];
  int m_left = 0;
  bit m_valid = 0;
  typedef struct {
    logic [2:0] we; logic [4:0] wa; logic [31:0] wd0, wd1, wd2;
    logic ae; logic [4:0] aa; logic [4:0] ra; logic [31:0] ed; logic er;
  } vec_t;
  vec_t vec [13];
  mp_reg_file_sb dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .al_en(al_en), .al_addr(al_addr), .init_done(init_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [32:0] m_read(input logic [4:0] a);
    logic [32:0] res;
    if (m_left > 0) return 33'h0;
    if (a == 5'd0) return {1'b1, 32'h0};
    res = {~m_pend[a], m_mem[a]};
    for (int i = 0; i < 3; i++)
      if (wr_en[i] && wr_addr[i*5 +: 5] == a) res = {1'b1, wr_data[i*32 +: 32]};
    return res;
  endfunction
  task automatic m_edge();
    if (rst) begin
      m_valid = 1;
      m_left = 32;
      for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0)
        for (int r = 0; r < 32; r++) begin m_mem[r] = 32'h0; m_pend[r] = 1'b0; end
    end else begin
      for (int i = 0; i < 3; i++)
        if (wr_en[i] && wr_addr[i*5 +: 5] != 5'd0) m_mem[wr_addr[i*5 +: 5]] = wr_data[i*32 +: 32];
      for (int i = 0; i < 3; i++) if (wr_en[i]) m_pend[wr_addr[i*5 +: 5]] = 1'b0;
      for (int j = 0; j < 4; j++) if (al_en[j]) m_pend[al_addr[j*5 +: 5]] = 1'b1;
      m_pend[0] = 1'b0;
    end
  endtask
  task automatic check_model();
    logic [32:0] e;
    if (!m_valid) return;
    chk("init_done", {31'h0, init_done}, {31'h0, m_left == 0});
    for (int p = 0; p < 8; p++) begin
      e = m_read(rd_addr[p*5 +: 5]);
      chk($sformatf("rd_data%0d", p), rd_data[p*32 +: 32], e[31:0]);
      chk($sformatf("rd_ready%0d", p), {31'h0, rd_ready[p]}, {31'h0, e[32]});
    end
  endtask
  task automatic advance();
    @(posedge clk);
    m_edge();
    #1;
  endtask
  task automatic step();
    #4;
    check_model();
    advance();
  endtask
  task automatic idle();
    rst = 0; wr_en = '0; wr_addr = '0; wr_data = '0; al_en = '0; al_addr = '0;
  endtask
  task automatic sweep_count(input string name);
    int n;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      rd_addr = {8{5'd5}};
      if (k < 32) begin
        wr_en = 3'b001; wr_addr = {3{5'd5}}; wr_data = {3{32'hDEAD}};
        al_en = 4'b0001; al_addr = {4{5'd5}};
      end
      #4;
      check_model();
      if (init_done !== 1'b1) n++;
      if (k == 32) chk({name, "_r5"}, rd_data[31:0], 32'h0);
      advance();
    end
    chk({name, "_len"}, n, 32);
  endtask
  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction
  initial begin
    vec[0]  = '{3'b101, 5'd7, 32'h11, 32'h22, 32'h33, 1'b0, 5'd0, 5'd7, 32'h33, 1'b1};
    vec[1]  = '{3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd7, 32'h33, 1'b1};
    vec[2]  = '{3'b001, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 5'd0, 5'd0, 32'h0, 1'b1};
    vec[3]  = '{3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 1'b1};
    vec[4]  = '{3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1, 5'd9, 5'd9, 32'h0, 1'b1};
    vec[5]  = '{3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 32'h0, 1'b0};
    vec[6]  = '{3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 32'h0, 1'b0};
    vec[7]  = '{3'b001, 5'd9, 32'h55, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 32'h55, 1'b1};
    vec[8]  = '{3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 32'h55, 1'b1};
    vec[9]  = '{3'b100, 5'd9, 32'h0, 32'h0, 32'h66, 1'b1, 5'd9, 5'd9, 32'h66, 1'b1};
    vec[10] = '{3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 32'h66, 1'b0};
    vec[11] = '{3'b010, 5'd9, 32'h0, 32'h77, 32'h0, 1'b0, 5'd0, 5'd9, 32'h77, 1'b1};
    vec[12] = '{3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 5'd9, 32'h77, 1'b1};
    idle();
    rd_addr = '0;
    rst = 1;
    step();
    sweep_count("sweep");
    for (int k = 0; k < 13; k++) begin
      idle();
      wr_en = vec[k].we; wr_addr = {3{vec[k].wa}}; wr_data = {vec[k].wd2, vec[k].wd1, vec[k].wd0};
      al_en = {3'b000, vec[k].ae}; al_addr = {4{vec[k].aa}}; rd_addr = {8{vec[k].ra}};
      #4;
      chk($sformatf("vec%0d_data", k), rd_data[31:0], vec[k].ed);
      chk($sformatf("vec%0d_ready", k), {31'h0, rd_ready[0]}, {31'h0, vec[k].er});
      check_model();
      advance();
    end
    for (int k = 0; k < 8; k++) begin
      idle();
      wr_en = 3'(1 << (k % 3)); wr_addr = {3{5'(10 + k)}}; wr_data = {3{32'((10 + k) * 32'h101)}};
      step();
    end
    idle();
    for (int p = 0; p < 8; p++) rd_addr[p*5 +: 5] = 5'(10 + p);
    #4;
    for (int p = 0; p < 8; p++) begin
      chk($sformatf("allport%0d_data", p), rd_data[p*32 +: 32], 32'((10 + p) * 32'h101));
      chk($sformatf("allport%0d_ready", p), {31'h0, rd_ready[p]}, 32'h1);
    end
    check_model();
    advance();
    idle();
    rst = 1;
    step();
    idle();
    for (int k = 0; k < 10; k++) step();
    rst = 1;
    step();
    sweep_count("midsweep");
    for (int k = 0; k < 400; k++) begin
      idle();
      wr_en = 3'($urandom_range(0, 7));
      al_en = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      for (int i = 0; i < 3; i++) begin wr_addr[i*5 +: 5] = rnd_addr(); wr_data[i*32 +: 32] = $urandom; end
      for (int j = 0; j < 4; j++) al_addr[j*5 +: 5] = rnd_addr();
      for (int p = 0; p < 8; p++) rd_addr[p*5 +: 5] = rnd_addr();
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
